// File: rtl/uart_pkg.sv
// Shared UART definitions. The transmitter uses them now and the receiver will reuse them.
package uart_pkg;

  // Data bits in each frame. Wider FIFO words are truncated to this width.
  localparam int unsigned UART_DATA_BITS = 8;

  // Transmitter frame sequencing.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_if.sv
// Link between the TX FIFO read port and the UART transmitter, plus the serial line.
interface uart_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] i_fifo_data;   // FIFO data_out
  logic                  i_fifo_empty;  // FIFO empty_out
  logic                  o_fifo_read;   // FIFO read_en_in, one-cycle pop
  logic                  o_tx;          // serial line, idle high
  logic                  o_busy;        // frame in progress

  // Transmitter side.
  modport master (
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_fifo_read,
    output o_tx,
    output o_busy
  );

  // FIFO / board side.
  modport slave (
    output i_fifo_data,
    output i_fifo_empty,
    input  o_fifo_read,
    input  o_tx,
    input  o_busy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps, and flags the wrap cycle.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The last count of a bit period is the bit boundary.
  assign o_tick = (cnt_q == CntMax);

  // Next count: wrap at the boundary, or restart when a frame is being loaded.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (i_clear || o_tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from the TX FIFO and sends each low byte as an
// 8N1 / 8N2 frame (start, 8 data bits LSB first, STOP_BITS stop bits).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic    i_clk,
  input logic    i_rst,
  uart_if.master bus
);

  localparam logic [2:0] LastData = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      fifo_read;
  logic                      tick;
  logic                      baud_clear;

  logic [DATA_WIDTH-1:0]     word;
  logic                      unused_word;

  assign word        = bus.i_fifo_data;
  // Only the low byte is sent; the rest of the word is deliberately dropped.
  assign unused_word = ^word;

  // Restart the bit timer so the start bit gets a full period.
  assign baud_clear = (state_q == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(baud_clear),
    .o_tick (tick)
  );

  // Frame sequencing: next state, shift register, bit index and FIFO pop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    fifo_read = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.i_fifo_empty) begin
          fifo_read = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        // The popped word is on the FIFO output during this cycle.
        shift_d = word[UART_DATA_BITS-1:0];
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // The index counts stop-bit periods here.
        if (tick) begin
          if (idx_q == LastStop) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the next cycle, registered so the pin never glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset drives the line idle immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.o_tx        = tx_q;
  assign bus.o_fifo_read = fifo_read;
  // Busy covers the pop cycle so the FIFO side sees no gap before LOAD.
  assign bus.o_busy      = (state_q != IDLE) || fifo_read;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (16-bit words / 1 stop, 8-bit words / 2 stops).
module tb_uart_tx;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_if #(.DATA_WIDTH(16)) bus1 ();
  uart_if #(.DATA_WIDTH(8))  bus2 ();

  uart_tx #(
    .DATA_WIDTH  (16),
    .CLKS_PER_BIT(Cpb),
    .STOP_BITS   (1)
  ) dut1 (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus1)
  );

  uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(Cpb),
    .STOP_BITS   (2)
  ) dut2 (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus2)
  );

  int checks   = 0;
  int failures = 0;

  // FIFO models: registered read data, registered empty flag.
  logic [15:0] q1[$];
  logic [7:0]  q2[$];
  logic        push1 = 1'b0;
  logic        push2 = 1'b0;
  logic [15:0] pval1 = '0;
  logic [7:0]  pval2 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q1.delete();
      bus1.i_fifo_empty <= 1'b1;
      bus1.i_fifo_data  <= '0;
    end else begin
      if (bus1.o_fifo_read && q1.size() != 0) bus1.i_fifo_data <= q1.pop_front();
      if (push1) q1.push_back(pval1);
      bus1.i_fifo_empty <= (q1.size() == 0);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q2.delete();
      bus2.i_fifo_empty <= 1'b1;
      bus2.i_fifo_data  <= '0;
    end else begin
      if (bus2.o_fifo_read && q2.size() != 0) bus2.i_fifo_data <= q2.pop_front();
      if (push2) q2.push_back(pval2);
      bus2.i_fifo_empty <= (q2.size() == 0);
    end
  end

  // Activity monitor: pops, pops while empty, low cycles on dut1's line.
  int pops1 = 0, pops2 = 0, bad1 = 0, bad2 = 0, low1 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.o_fifo_read) begin
        pops1 <= pops1 + 1;
        if (bus1.i_fifo_empty) bad1 <= bad1 + 1;
      end
      if (bus2.o_fifo_read) begin
        pops2 <= pops2 + 1;
        if (bus2.i_fifo_empty) bad2 <= bad2 + 1;
      end
      if (bus1.o_tx !== 1'b1) low1 <= low1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [15:0] v);
    if (sel == 1) begin
      push1 = 1'b1;
      pval1 = v;
    end else begin
      push2 = 1'b1;
      pval2 = v[7:0];
    end
    @(negedge clk);
    push1 = 1'b0;
    push2 = 1'b0;
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 1) ? bus1.o_tx : bus2.o_tx;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? bus1.o_busy : bus2.o_busy;
  endfunction

  // Leaves the caller on the negedge of the first start-bit cycle.
  task automatic wait_start(input int sel, input string tag);
    int n = 0;
    while (tx_of(sel) !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, 32'(n < 100), 32'd1);
  endtask

  // Samples every cycle of the frame; exp[0] is the start bit, exp[nbits-1] the last stop bit.
  // Ends on the negedge of the last stop-bit cycle.
  task automatic check_frame(input int sel, input logic [10:0] exp, input int nbits,
                             input string tag);
    logic [3:0] s;
    logic       busy_all;
    busy_all = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        s[c]     = tx_of(sel);
        busy_all = busy_all & busy_of(sel);
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(s), {28'd0, {4{exp[b]}}});
    end
    chk({tag, "_busy_in_frame"}, 32'(busy_all), 32'd1);
  endtask

  // After check_frame: busy must drop on the cycle after the stop bit (FIFO empty).
  task automatic check_end(input int sel, input string tag);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy_of(sel)), 32'd0);
    chk({tag, "_tx_after"}, 32'(tx_of(sel)), 32'd1);
  endtask

  initial begin
    logic [2:0] gap;
    logic       gap_read;
    int         p_snap, l_snap;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx1", 32'(bus1.o_tx), 32'd1);
    chk("rst_read1", 32'(bus1.o_fifo_read), 32'd0);
    chk("rst_busy1", 32'(bus1.o_busy), 32'd0);
    chk("rst_tx2", 32'(bus2.o_tx), 32'd1);
    chk("rst_busy2", 32'(bus2.o_busy), 32'd0);
    rst = 1'b0;

    // Empty FIFO for 100 cycles: line idle, no pops
    repeat (100) @(negedge clk);
    #1;
    chk("idle_low_cycles", 32'(low1), 32'd0);
    chk("idle_pops1", 32'(pops1), 32'd0);
    chk("idle_pops2", 32'(pops2), 32'd0);
    chk("idle_busy1", 32'(bus1.o_busy), 32'd0);
    @(negedge clk);

    // 0xA5: 0 | 1 0 1 0 0 1 0 1 | 1
    push(1, 16'h00A5);
    wait_start(1, "a5");
    check_frame(1, 11'b01101001010, 10, "a5");
    check_end(1, "a5");
    #1;
    chk("a5_pops", 32'(pops1), 32'd1);

    // 0x00 then 0xFF back-to-back; exactly two idle-high cycles between frames
    @(negedge clk);
    push(1, 16'h0000);
    push(1, 16'h00FF);
    wait_start(1, "b00");
    check_frame(1, 11'b01000000000, 10, "b00");
    gap_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      gap[i] = bus1.o_tx;
      if (i == 0) gap_read = bus1.o_fifo_read;
    end
    chk("gap_shape", 32'(gap), 32'b011);
    chk("gap_pop_pulse", 32'(gap_read), 32'd1);
    check_frame(1, 11'b01111111110, 10, "bff");
    check_end(1, "bff");
    #1;
    chk("b2b_pops", 32'(pops1), 32'd3);
    chk("b2b_pop_while_empty", 32'(bad1), 32'd0);

    // Two stop bits: 0x55, 44-cycle frame
    @(negedge clk);
    push(2, 16'h0055);
    wait_start(2, "s55");
    check_frame(2, 11'b11010101010, 11, "s55");
    check_end(2, "s55");
    #1;
    chk("s55_pops", 32'(pops2), 32'd1);
    chk("s55_pop_while_empty", 32'(bad2), 32'd0);

    // 16-bit word: only 0xC3 goes out
    @(negedge clk);
    push(1, 16'h12C3);
    wait_start(1, "w12c3");
    check_frame(1, 11'b01110000110, 10, "w12c3");
    check_end(1, "w12c3");

    // Reset during data bit 3 of 0x3C
    @(negedge clk);
    push(1, 16'h003C);
    wait_start(1, "r3c");
    repeat (17) @(negedge clk);
    chk("r3c_bit3_level", 32'(bus1.o_tx), 32'd1);
    chk("r3c_busy_before", 32'(bus1.o_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("r3c_async_tx", 32'(bus1.o_tx), 32'd1);
    chk("r3c_async_busy", 32'(bus1.o_busy), 32'd0);
    chk("r3c_async_read", 32'(bus1.o_fifo_read), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    p_snap = pops1;
    l_snap = low1;
    repeat (60) @(negedge clk);
    #1;
    chk("r3c_no_pop_after", 32'(pops1), 32'(p_snap));
    chk("r3c_no_tx_after", 32'(low1), 32'(l_snap));
    chk("r3c_busy_after", 32'(bus1.o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that drains the top-level TX FIFO (the FIFO whose write side the memory map feeds from CPU stores) and serializes each word onto the board `tx` pin.
- Frame is 8N1 or 8N2: start bit, 8 data bits LSB first, STOP_BITS stop bits.
- Sits between the FIFO read port (data_out / empty_out / read_en_in) and the `tx` output of LEG.

Parameters:
- DATA_WIDTH, 8: width of FIFO words. Must be ≥ 8. Only bits [7:0] are transmitted.
- CLKS_PER_BIT, 868: i_clk cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_fifo_data  in  DATA_WIDTH  FIFO data_out.
- i_fifo_empty  in  1  FIFO empty_out.
- o_fifo_read  out  1  FIFO read_en_in; single-cycle pop pulse.
- o_tx  out  1  serial line; idle high.
- o_busy  out  1  high from pop until the end of the last stop bit.

Behaviour:
- One clock domain, i_clk. Reset i_rst is asynchronous, active-high; all flops clear immediately when it asserts.
- Reset values: o_tx=1, o_fifo_read=0, o_busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- FIFO contract: o_fifo_read is sampled at the rising edge. The popped word is valid on i_fifo_data in the following cycle. o_fifo_read is never asserted while i_fifo_empty=1.
- States:
  - IDLE: o_tx=1. If !i_fifo_empty, assert o_fifo_read for this cycle and go to LOAD. Otherwise stay.
  - LOAD (1 cycle): capture i_fifo_data[7:0] into the shift register, clear the baud counter, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- o_tx is driven from a flop, so the line is glitch-free. The start bit appears on o_tx the cycle after LOAD.
- o_busy=1 in LOAD, START, DATA and STOP. o_busy is also high in the IDLE cycle that asserts o_fifo_read.
- Frame length: exactly (9+STOP_BITS)*CLKS_PER_BIT cycles of o_tx from start-bit edge to end of stop.
- Back-to-back words: the IDLE re-check happens on the cycle after STOP completes. The inter-frame idle-high gap is therefore exactly 2 cycles (IDLE pop cycle plus LOAD), in addition to the stop bits.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs on the wrap. The counter width is $clog2(CLKS_PER_BIT).
- The bit index is 3 bits and wraps only by a state change, never by overflow.
- Empty FIFO: no pop, o_tx stays high indefinitely.
- i_fifo_empty deasserting mid-frame has no effect until the return to IDLE.
- FIFO becoming empty after the pop is irrelevant: data is already captured in LOAD.
- Reset mid-frame: o_tx returns high asynchronously and the partial frame is abandoned. The popped word is lost; there is no retransmit.
- Upper bits [DATA_WIDTH-1:8] of i_fifo_data are ignored.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, LOAD, START, DATA, STOP};
  - localparam UART_DATA_BITS=8.
- RX will reuse the same package.
- One natural sub-module: uart_baud_gen. It takes CLKS_PER_BIT, i_clk, i_rst and a clear input, and produces a one-cycle o_tick on the counter wrap. The counter is cleared in LOAD.
- The shift register and FSM stay in uart_tx.
- Instantiation in LEG connects fifo data_out/empty_out/read_en_in and the top-level `tx`.

Test Plan:
- Bench setup: CLKS_PER_BIT=4, STOP_BITS=1.
- Reset, FIFO empty for 100 cycles -> o_tx=1, o_fifo_read never asserted, o_busy=0.
- Push 0xA5 -> one o_fifo_read pulse. o_tx sequence, each bit 4 cycles: 0, then 1,0,1,0,0,1,0,1, then 1. The frame spans 40 cycles; o_busy falls after the stop bit.
- Push 0x00 then 0xFF back-to-back -> two frames. The idle-high gap between the end of stop 1 and start 2 is exactly 2 cycles. Exactly 2 pops occur, with no pop while empty.
- STOP_BITS=2, push 0x55 -> stop period is 8 cycles high; total frame is 44 cycles.
- Assert i_rst during data bit 3 of 0x3C -> o_tx=1 in the same cycle (asynchronous). State returns to IDLE and o_busy=0. After release with the FIFO empty, nothing is transmitted.
- DATA_WIDTH=16, push 0x12C3 -> the serialized byte is 0xC3 only (bits 1,1,0,0,0,0,1,1 LSB first).
